// File: rtl/weight_fetch_ctrl.sv
// Weight BRAM sequencer: host write port while idle, full-row read streaming
// through a 2-entry skid buffer to the MAC on START.
module weight_fetch_ctrl #(
  parameter int DEPTH  = 28,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              ABORT,
  output logic              BUSY,
  output logic              DONE,
  input  logic              LD_VALID,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [DATA_W-1:0] LD_DATA,
  output logic              LD_READY,
  output logic              BRAM_EN,
  output logic              BRAM_WE,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic [DATA_W-1:0] BRAM_DI,
  input  logic [DATA_W-1:0] BRAM_DO,
  output logic [DATA_W-1:0] W_DATA,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic              W_LAST,
  output logic [ADDR_W-1:0] W_IDX
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_ptr;
  logic [1:0]        count;
  logic [DATA_W-1:0] buf0_data, buf1_data;
  logic [ADDR_W-1:0] buf0_idx, buf1_idx;

  logic       pop, issue, head_last, wr_ok, abort_act;
  logic [2:0] room;

  // BRAM_DO is already valid at the posedge closing the issue cycle, so the
  // read word is captured there; occupancy is therefore the buffer count alone.
  always_comb begin
    abort_act = (state != S_IDLE) && ABORT;
    pop       = (count != 2'd0) && W_READY;
    room      = {1'b0, count} - {2'b00, pop};
    issue     = (state == S_FETCH) && !ABORT && (room < 3'd2);
    head_last = (count != 2'd0) && (buf0_idx == LAST_ADDR);
    wr_ok     = LD_VALID && LD_READY && ({1'b0, LD_ADDR} < DEPTH_W);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START && !ABORT) state_nxt = S_FETCH;
      S_FETCH: if (issue && rd_ptr == LAST_ADDR) state_nxt = S_DRAIN;
      S_DRAIN: if (pop && head_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_act) state_nxt = S_IDLE;
  end

  always_comb begin
    BUSY      = (state != S_IDLE);
    DONE      = (state == S_DONE);
    LD_READY  = (state == S_IDLE) && !START;
    BRAM_EN   = wr_ok || issue;
    BRAM_WE   = wr_ok;
    BRAM_ADDR = '0;
    if (wr_ok)      BRAM_ADDR = LD_ADDR;
    else if (issue) BRAM_ADDR = rd_ptr;
    BRAM_DI   = LD_DATA;
    W_VALID   = (count != 2'd0);
    W_DATA    = W_VALID ? buf0_data : '0;
    W_IDX     = W_VALID ? buf0_idx : '0;
    W_LAST    = head_last;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr    <= '0;
      count     <= '0;
      buf0_data <= '0;
      buf0_idx  <= '0;
      buf1_data <= '0;
      buf1_idx  <= '0;
    end else if (abort_act) begin
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (state == S_IDLE && START) rd_ptr <= '0;
      else if (issue && rd_ptr != LAST_ADDR) rd_ptr <= rd_ptr + ADDR_W'(1);

      case ({issue, pop})
        2'b10: begin
          if (count == 2'd0) begin
            buf0_data <= BRAM_DO;
            buf0_idx  <= rd_ptr;
          end else begin
            buf1_data <= BRAM_DO;
            buf1_idx  <= rd_ptr;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          buf0_data <= buf1_data;
          buf0_idx  <= buf1_idx;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            buf0_data <= BRAM_DO;
            buf0_idx  <= rd_ptr;
          end else begin
            buf0_data <= buf1_data;
            buf0_idx  <= buf1_idx;
            buf1_data <= BRAM_DO;
            buf1_idx  <= rd_ptr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: behavioural BRAM, idle write-path vector table,
// and streamed rows checked against an array model of the expected BRAM contents.
module tb_weight_fetch_ctrl;
  localparam int DEPTH  = 28;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  logic              CLK, RST_N, START, ABORT, BUSY, DONE;
  logic              LD_VALID, LD_READY, BRAM_EN, BRAM_WE;
  logic [ADDR_W-1:0] LD_ADDR, BRAM_ADDR, W_IDX;
  logic [DATA_W-1:0] LD_DATA, BRAM_DI, BRAM_DO, W_DATA;
  logic              W_VALID, W_READY, W_LAST;

  weight_fetch_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE),
    .LD_VALID(LD_VALID), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA), .LD_READY(LD_READY),
    .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_ADDR(BRAM_ADDR), .BRAM_DI(BRAM_DI),
    .BRAM_DO(BRAM_DO), .W_DATA(W_DATA), .W_VALID(W_VALID), .W_READY(W_READY),
    .W_LAST(W_LAST), .W_IDX(W_IDX)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [DATA_W-1:0] bram [2**ADDR_W];
  always @(negedge CLK) begin
    if (BRAM_EN) begin
      if (BRAM_WE) bram[BRAM_ADDR] <= BRAM_DI;
      else         BRAM_DO <= bram[BRAM_ADDR];
    end
  end

  logic [DATA_W-1:0] ref_mem [DEPTH];
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    bit                start, abort, ld_valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                e_ready, e_en, e_we;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_w_valid"}, W_VALID, 0);
    chk({tag, "_w_last"}, W_LAST, 0);
    chk({tag, "_w_idx"}, W_IDX, 0);
    chk({tag, "_w_data"}, W_DATA, 0);
    chk({tag, "_bram_en"}, BRAM_EN, 0);
    chk({tag, "_bram_we"}, BRAM_WE, 0);
    chk({tag, "_bram_addr"}, BRAM_ADDR, 0);
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    bit in_range;
    in_range = (int'(addr) < DEPTH);
    tick();
    LD_VALID = 1'b1; LD_ADDR = addr; LD_DATA = data;
    #2;
    chk("ld_ready", LD_READY, 1);
    chk("ld_bram_en", BRAM_EN, in_range);
    chk("ld_bram_we", BRAM_WE, in_range);
    if (in_range) begin
      chk("ld_bram_addr", BRAM_ADDR, addr);
      ref_mem[addr] = data;
    end
    tick();
    LD_VALID = 1'b0;
  endtask

  // stop_kind 0: ABORT once stop_at words have been popped; 1: reset at that point.
  task automatic do_stream(input int pct, input int stop_at, input int stop_kind,
                           input bit collide, input bit ld_busy);
    int pops = 0, reads = 0, cyc = 1, first = -1, last_pop = -10, dones = 0;
    int max_ahead = 0, we_busy = 0;
    bit fin = 0;
    tick();
    START = 1'b1;
    if (collide) begin
      LD_VALID = 1'b1; LD_ADDR = 5'd2; LD_DATA = 16'hDEAD;
    end
    #2;
    if (collide) begin
      chk("collide_ld_ready", LD_READY, 0);
      chk("collide_bram_we", BRAM_WE, 0);
    end
    tick();
    START = 1'b0;
    LD_VALID = 1'b0;
    if (ld_busy) begin
      LD_VALID = 1'b1; LD_ADDR = 5'd6; LD_DATA = 16'h6666;
    end
    while (!fin && cyc < 600) begin
      W_READY = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      if (stop_at >= 0 && pops == stop_at) begin
        fin = 1;
        if (stop_kind == 0) begin
          W_READY = 1'b0; ABORT = 1'b1;
          tick();
          ABORT = 1'b0;
          #2;
          chk("abort_busy", BUSY, 0);
          chk("abort_w_valid", W_VALID, 0);
          for (int k = 0; k < 3; k++) begin
            if (DONE) dones++;
            tick(); #2;
          end
          chk("abort_no_done", dones, 0);
        end else begin
          #1; RST_N = 1'b0; #1;
          chk_zero_outputs("midreset");
          tick();
          RST_N = 1'b1;
        end
      end else begin
        #2;
        if (BRAM_EN && !BRAM_WE) reads++;
        if (BUSY && BRAM_WE) we_busy++;
        if (W_VALID) begin
          if (first < 0) first = cyc;
          if (pops < DEPTH) begin
            chk("w_data", W_DATA, ref_mem[pops]);
            chk("w_idx", W_IDX, pops);
            chk("w_last", W_LAST, pops == DEPTH - 1);
          end else chk("extra_word", pops, DEPTH - 1);
        end
        if (W_VALID && W_READY) begin
          if (pct >= 100) chk("pop_cycle", cyc, pops + 2);
          pops++;
          last_pop = cyc;
        end
        if (reads - pops > max_ahead) max_ahead = reads - pops;
        if (DONE) begin
          dones++;
          chk("done_cycle", cyc, last_pop + 1);
          fin = 1;
        end
        tick();
        cyc++;
      end
    end
    if (!fin) chk("stream_timeout", 0, 1);
    if (stop_at < 0) begin
      chk("pop_count", pops, DEPTH);
      chk("done_count", dones, 1);
      chk("first_valid_latency", first, 2);
      chk("reads_ahead_le3", max_ahead <= 3, 1);
    end
    if (ld_busy) begin
      chk("busy_no_write", we_busy, 0);
      #2;
      chk("idle_write_we", BRAM_WE, 1);
      chk("idle_write_addr", BRAM_ADDR, 6);
      ref_mem[6] = 16'h6666;
      tick();
      LD_VALID = 1'b0;
    end
    W_READY = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; ABORT = 1'b0; LD_VALID = 1'b0;
    LD_ADDR = '0; LD_DATA = '0; W_READY = 1'b0;
    vecs[0] = '{0, 0, 1, 5'd3,  16'hAAAA, 1, 1, 1};
    vecs[1] = '{0, 0, 1, 5'd30, 16'hBBBB, 1, 0, 0};
    vecs[2] = '{0, 0, 0, 5'd4,  16'hCCCC, 1, 0, 0};
    vecs[3] = '{1, 1, 1, 5'd5,  16'hDDDD, 0, 0, 0};
    vecs[4] = '{0, 1, 1, 5'd31, 16'hEEEE, 1, 0, 0};
    vecs[5] = '{0, 0, 1, 5'd27, 16'h1234, 1, 1, 1};

    repeat (2) @(posedge CLK);
    #2;
    chk_zero_outputs("reset");
    tick();
    RST_N = 1'b1;

    foreach (vecs[i]) begin
      tick();
      START = vecs[i].start; ABORT = vecs[i].abort; LD_VALID = vecs[i].ld_valid;
      LD_ADDR = vecs[i].addr; LD_DATA = vecs[i].data;
      #2;
      chk($sformatf("vec%0d_ld_ready", i), LD_READY, vecs[i].e_ready);
      chk($sformatf("vec%0d_bram_en", i), BRAM_EN, vecs[i].e_en);
      chk($sformatf("vec%0d_bram_we", i), BRAM_WE, vecs[i].e_we);
      if (vecs[i].e_we) begin
        chk($sformatf("vec%0d_bram_addr", i), BRAM_ADDR, vecs[i].addr);
        ref_mem[vecs[i].addr] = vecs[i].data;
      end
      tick();
      START = 1'b0; ABORT = 1'b0; LD_VALID = 1'b0;
      #2;
      chk($sformatf("vec%0d_stays_idle", i), BUSY, 0);
    end

    for (int i = 0; i < DEPTH; i++) host_write(ADDR_W'(i), DATA_W'(16'h0100 + i));
    do_stream(100, -1, 0, 0, 0);

    do_stream(100, 10, 1, 0, 0);
    do_stream(100, -1, 0, 0, 0);

    for (int i = 0; i < DEPTH; i++) host_write(ADDR_W'(i), DATA_W'($urandom));
    do_stream(50, -1, 0, 0, 0);
    do_stream(50, -1, 0, 0, 0);

    do_stream(100, -1, 0, 1, 1);
    host_write(5'd30, 16'hBEEF);

    do_stream(100, 5, 0, 0, 0);
    do_stream(70, -1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
